// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between NrHosts hosts.
// An in-order ID FIFO routes each response back to the host that issued the request.
module bus_host_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                   clk_sys_i,
  input  logic                                   rst_sys_ni,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts*AddrWidth-1:0]           host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0]         host_be_i,
  input  logic [NrHosts*DataWidth-1:0]           host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [DataWidth-1:0]                   host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic                                   dev_req_o,
  input  logic                                   dev_gnt_i,
  output logic [AddrWidth-1:0]                   dev_addr_o,
  output logic                                   dev_we_o,
  output logic [DataWidth/8-1:0]                 dev_be_o,
  output logic [DataWidth-1:0]                   dev_wdata_o,
  input  logic                                   dev_rvalid_i,
  input  logic [DataWidth-1:0]                   dev_rdata_i,
  input  logic                                   dev_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
  output logic                                   protocol_err_o
);

  localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned BeW  = DataWidth / 8;

  logic [IdxW-1:0] r_ptr;
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_head, r_tail;
  logic [CntW-1:0] r_count;
  logic            r_proto_err;

  logic [IdxW-1:0] w_scan, w_sel, w_mux, w_head_id;
  logic            w_found, w_full, w_empty, w_req, w_gnt, w_pop;
  int unsigned     w_idx;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    w_scan  = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NrHosts; k++) begin
      w_idx = (32'(r_ptr) + k) % NrHosts;
      if (!w_found && host_req_i[w_idx[IdxW-1:0]]) begin
        w_found = 1'b1;
        w_scan  = w_idx[IdxW-1:0];
      end
    end
  end

  assign w_sel     = r_lock ? r_lock_idx : w_scan;
  assign w_full    = (r_count == CntW'(MaxOutstanding));
  assign w_empty   = (r_count == '0);
  assign w_req     = (|host_req_i) & ~w_full;
  assign w_gnt     = w_req & dev_gnt_i;
  assign w_pop     = dev_rvalid_i & ~w_empty;
  assign w_mux     = w_req ? w_sel : '0;
  assign w_head_id = r_fifo[r_head];

  assign dev_req_o   = w_req;
  assign dev_addr_o  = host_addr_i[32'(w_mux) * AddrWidth +: AddrWidth];
  assign dev_we_o    = host_we_i[w_mux];
  assign dev_be_o    = host_be_i[32'(w_mux) * BeW +: BeW];
  assign dev_wdata_o = host_wdata_i[32'(w_mux) * DataWidth +: DataWidth];

  assign host_rdata_o   = dev_rdata_i;
  assign outstanding_o  = r_count;
  assign protocol_err_o = r_proto_err;

  always_comb begin
    host_gnt_o             = '0;
    host_rvalid_o          = '0;
    host_err_o             = '0;
    host_gnt_o[w_sel]      = w_gnt;
    host_rvalid_o[w_head_id] = w_pop;
    host_err_o[w_head_id]  = w_pop & dev_err_i;
  end

  // Arbitration state: pointer advances past the winner; lock pins a stalled selection.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_gnt) begin
      r_lock <= 1'b0;
      if (w_sel == IdxW'(NrHosts - 1)) r_ptr <= '0;
      else                             r_ptr <= w_sel + 1'b1;
    end else if (w_req) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) r_fifo[i] <= '0;
    end else begin
      if (w_gnt) begin
        r_fifo[r_tail] <= w_sel;
        if (r_tail == PtrW'(MaxOutstanding - 1)) r_tail <= '0;
        else                                     r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        if (r_head == PtrW'(MaxOutstanding - 1)) r_head <= '0;
        else                                     r_head <= r_head + 1'b1;
      end
      if (w_gnt && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_gnt && w_pop) r_count <= r_count - 1'b1;
      if (dev_rvalid_i && w_empty) r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter: expected grant owners are queued when issued
// and popped to check response routing.
module tb_bus_host_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we, gnt, rvalid, err;
  logic [63:0] addr, wdata;
  logic [7:0]  be;
  logic        dgnt, drv, derr, dreq, dwe, perr;
  logic [31:0] drdata, rdata, daddr, dwdata;
  logic [3:0]  dbe;
  logic [1:0]  outst;

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  bus_host_arbiter dut (
    .clk_sys_i     (clk),
    .rst_sys_ni    (rst_n),
    .host_req_i    (req),
    .host_gnt_o    (gnt),
    .host_addr_i   (addr),
    .host_we_i     (we),
    .host_be_i     (be),
    .host_wdata_i  (wdata),
    .host_rvalid_o (rvalid),
    .host_rdata_o  (rdata),
    .host_err_o    (err),
    .dev_req_o     (dreq),
    .dev_gnt_i     (dgnt),
    .dev_addr_o    (daddr),
    .dev_we_o      (dwe),
    .dev_be_o      (dbe),
    .dev_wdata_o   (dwdata),
    .dev_rvalid_i  (drv),
    .dev_rdata_i   (drdata),
    .dev_err_i     (derr),
    .outstanding_o (outst),
    .protocol_err_o(perr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant to host h expected this cycle; record it for response routing.
  task automatic exp_gnt(input string tag, input int h);
    logic [1:0] oh;
    oh = 2'b01 << h;
    chk(tag, gnt, oh);
    exp_q.push_back(h);
    m_ptr = (h + 1) % 2;
  endtask

  task automatic exp_resp(input string tag);
    logic [1:0] oh;
    int id;
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 1, 0);
    end else begin
      id = exp_q.pop_front();
      oh = 2'b01 << id;
      chk(tag, rvalid, oh);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    dgnt = 1'b0; drv = 1'b0; derr = 1'b0; drdata = '0;
    #1 rst_n = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_outst", outst, 0);
    chk("rst_perr", perr, 0);
    chk("rst_dreq", dreq, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    rst_n = 1'b1;

    // Single host read
    cyc(); req = 2'b01; addr = {32'h0, 32'h0010_0004}; we = 2'b00; be = 8'h0F; dgnt = 1'b1;
    #1 chk("single_dreq", dreq, 1); chk("single_addr", daddr, 32'h0010_0004);
    chk("single_we", dwe, 0); chk("single_be", dbe, 4'hF);
    exp_gnt("single_gnt", 0);
    cyc(); req = 2'b00; dgnt = 1'b0; drv = 1'b1; drdata = 32'hDEAD_BEEF;
    #1 chk("single_outst1", outst, 1); exp_resp("single_rvalid");
    chk("single_rdata", rdata, 32'hDEAD_BEEF); chk("single_err", err, 0);
    cyc(); drv = 1'b0;
    #1 chk("single_outst0", outst, 0);

    // Fairness: both hosts requesting, responses one cycle behind
    cyc(); req = 2'b11; dgnt = 1'b1; wdata = {32'h1111_1111, 32'h0000_0000}; we = 2'b11;
    #1 chk("fair_wdata", dwdata, (m_ptr == 1) ? 32'h1111_1111 : 32'h0);
    exp_gnt("fair_gnt0", m_ptr);
    for (int k = 1; k < 5; k++) begin
      cyc(); drv = 1'b1; drdata = 32'(k);
      #1 exp_resp("fair_rvalid"); chk("fair_rdata", rdata, 32'(k));
      chk("fair_outst", outst, 1); exp_gnt("fair_gnt", m_ptr);
    end
    cyc(); req = 2'b00; dgnt = 1'b0;
    #1 exp_resp("fair_rvalid_last");
    cyc(); drv = 1'b0;
    #1 chk("fair_outst0", outst, 0);

    // Stall lock: host1 alone, host0 joins while device stalls
    addr = {32'hA1A1_0001, 32'hB0B0_0000};
    cyc(); req = 2'b10; dgnt = 1'b0;
    #1 chk("lock_dreq", dreq, 1); chk("lock_addr1", daddr, 32'hA1A1_0001); chk("lock_gnt1", gnt, 0);
    cyc(); req = 2'b11;
    #1 chk("lock_addr2", daddr, 32'hA1A1_0001); chk("lock_gnt2", gnt, 0);
    cyc();
    #1 chk("lock_addr3", daddr, 32'hA1A1_0001); chk("lock_gnt3", gnt, 0);
    cyc(); dgnt = 1'b1;
    #1 chk("lock_addr4", daddr, 32'hA1A1_0001); exp_gnt("lock_gnt_h1", 1);
    cyc(); req = 2'b01;
    #1 chk("lock_addr5", daddr, 32'hB0B0_0000); exp_gnt("lock_gnt_h0", 0);

    // Full FIFO: no grant even with a pop in the same cycle
    cyc(); req = 2'b10;
    #1 chk("full_outst", outst, 2); chk("full_dreq", dreq, 0); chk("full_gnt", gnt, 0);
    cyc(); drv = 1'b1; derr = 1'b1;
    #1 exp_resp("full_rvalid"); chk("full_err", err, 2'b10);
    chk("full_dreq_pop", dreq, 0); chk("full_gnt_pop", gnt, 0);

    // Simultaneous push and pop at occupancy 1
    cyc(); derr = 1'b0;
    #1 chk("pp_outst_pre", outst, 1); chk("pp_dreq", dreq, 1);
    exp_resp("pp_rvalid_old"); chk("pp_err", err, 0); exp_gnt("pp_gnt", 1);
    cyc(); req = 2'b00; dgnt = 1'b0;
    #1 chk("pp_outst_post", outst, 1); exp_resp("pp_rvalid_new");
    cyc(); drv = 1'b0;
    #1 chk("pp_outst0", outst, 0); chk("pp_perr", perr, 0);

    // Spurious response
    cyc(); drv = 1'b1;
    #1 chk("spur_rvalid", rvalid, 0); chk("spur_err", err, 0);
    cyc(); drv = 1'b0;
    #1 chk("spur_perr", perr, 1); chk("spur_outst", outst, 0);
    cyc();
    #1 chk("spur_perr_sticky", perr, 1);

    // Reset mid-transaction with two outstanding
    cyc(); req = 2'b01; dgnt = 1'b1;
    #1 exp_gnt("rst_setup_g0", 0);
    cyc();
    #1 exp_gnt("rst_setup_g1", 0);
    cyc(); req = 2'b00; dgnt = 1'b0;
    #1 chk("rst_setup_outst", outst, 2);
    rst_n = 1'b0;
    #1 chk("mid_rst_outst", outst, 0); chk("mid_rst_perr", perr, 0);
    exp_q.delete();
    cyc(); rst_n = 1'b1; req = 2'b11; dgnt = 1'b0;
    #1 chk("post_rst_ptr_addr", daddr, 32'hB0B0_0000); chk("post_rst_gnt", gnt, 0);
    cyc(); dgnt = 1'b1;
    #1 exp_gnt("post_rst_gnt_h0", 0);
    cyc(); req = 2'b00; dgnt = 1'b0; drv = 1'b1;
    #1 exp_resp("post_rst_rvalid");
    cyc(); drv = 1'b0;
    #1 chk("post_rst_outst0", outst, 0); chk("post_rst_perr", perr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
